// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions for the modulator and demodulator: default widths,
// accumulator sizing and the square-carrier phase.
package bpsk_pkg;

  localparam int DATA_W_DEF    = 24;
  localparam int SPS_DEF       = 8;
  localparam int WORD_BITS_DEF = 24;

  function automatic int acc_width(input int data_w, input int sps);
    return data_w + $clog2(sps) + 1;
  endfunction

  // 0 selects the +1 half of the symbol, 1 selects the -1 half
  function automatic logic carrier_sign(input int smp_cnt, input int sps);
    return (smp_cnt >= sps / 2);
  endfunction

endpackage

// File: rtl/bpsk_symbol_correlator.sv
// Per-symbol correlator: multiplies each accepted sample by the square carrier,
// accumulates over SPS samples and slices one bit at the last sample.
module bpsk_symbol_correlator
  import bpsk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPS    = SPS_DEF,
  localparam int ACC_W = acc_width(DATA_W, SPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     accept,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     smp_last,
  output logic                     bit_valid,
  output logic                     sym_bit,
  output logic signed [ACC_W-1:0]  acc_next
);

  localparam int SMP_W = $clog2(SPS);

  logic [SMP_W-1:0]        smp_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] smp_ext;

  assign smp_ext   = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign acc_next  = carrier_sign(int'(smp_cnt), SPS) ? (acc - smp_ext) : (acc + smp_ext);
  assign smp_last  = (smp_cnt == SMP_W'(SPS - 1));
  assign bit_valid = accept & smp_last;
  // a zero correlation is sliced as 1
  assign sym_bit   = ~acc_next[ACC_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt <= '0;
      acc     <= '0;
    end else if (clear) begin
      smp_cnt <= '0;
      acc     <= '0;
    end else if (accept) begin
      if (smp_last) begin
        smp_cnt <= '0;
        acc     <= '0;
      end else begin
        smp_cnt <= smp_cnt + SMP_W'(1);
        acc     <= acc_next;
      end
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK receive demodulator: correlates symbols, packs WORD_BITS bits MSB-first
// into a word and offers it on out_valid/out_ready. Optional squelch statistics
// are built when BPSK_DEMOD_SQUELCH_EN is defined.
module bpsk_demodulator
  import bpsk_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SPS       = SPS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF,
  localparam int ACC_W    = acc_width(DATA_W, SPS)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     align,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     overrun
`ifdef BPSK_DEMOD_SQUELCH_EN
  ,
  input  logic [ACC_W-1:0]         squelch_thr,
  output logic [15:0]              low_conf_cnt
`endif
);

  localparam int BC_W = $clog2(WORD_BITS + 1);

  logic                    accept;
  logic                    smp_last;
  logic                    bit_valid;
  logic                    sym_bit;
  logic signed [ACC_W-1:0] acc_next;
  logic [BC_W-1:0]         bit_cnt;
  logic [WORD_BITS-1:0]    sr;
  logic [WORD_BITS-1:0]    sr_next;
  logic                    bit_last;
  logic                    word_end;

  assign bit_last = (bit_cnt == BC_W'(WORD_BITS - 1));
  // only the sample that would complete a word can be held off
  assign in_ready = ~(out_valid & ~out_ready & smp_last & bit_last);
  assign accept   = in_valid & in_ready & ~align;
  assign sr_next  = WORD_BITS'({sr, sym_bit});
  assign word_end = bit_valid & bit_last;

  bpsk_symbol_correlator #(
    .DATA_W (DATA_W),
    .SPS    (SPS)
  ) u_corr (
    .clk       (CLOCK_50),
    .rst       (reset),
    .accept    (accept),
    .clear     (align),
    .in_data   (in_data),
    .smp_last  (smp_last),
    .bit_valid (bit_valid),
    .sym_bit   (sym_bit),
    .acc_next  (acc_next)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      sr      <= '0;
      overrun <= 1'b0;
    end else if (align) begin
      bit_cnt <= '0;
      sr      <= '0;
      overrun <= 1'b0;
    end else begin
      if (in_valid & ~in_ready)
        overrun <= 1'b1;
      if (bit_valid) begin
        sr      <= sr_next;
        bit_cnt <= bit_last ? '0 : bit_cnt + BC_W'(1);
      end
    end
  end

  // output register is left alone by align so a pending word survives
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid & out_ready)
        out_valid <= 1'b0;
      if (word_end & ~align) begin
        out_valid <= 1'b1;
        out_data  <= DATA_W'(sr_next);
      end
    end
  end

`ifdef BPSK_DEMOD_SQUELCH_EN
  logic [ACC_W-1:0] acc_mag;

  assign acc_mag = acc_next[ACC_W-1] ? ACC_W'(-acc_next) : ACC_W'(acc_next);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      low_conf_cnt <= '0;
    else if (align)
      low_conf_cnt <= '0;
    else if (bit_valid && (acc_mag < squelch_thr) && (low_conf_cnt != 16'hFFFF))
      low_conf_cnt <= low_conf_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator (SPS=8, WORD_BITS=24). Squelch checks run
// when BPSK_DEMOD_SQUELCH_EN is defined.
module tb_bpsk_demodulator;

  localparam int DATA_W = 24;
  localparam int ACC_W  = DATA_W + 3 + 1;

  logic                     CLOCK_50 = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     align;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic                     overrun;
`ifdef BPSK_DEMOD_SQUELCH_EN
  logic [ACC_W-1:0]         squelch_thr;
  logic [15:0]              low_conf_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  bpsk_demodulator dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .align     (align),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overrun   (overrun)
`ifdef BPSK_DEMOD_SQUELCH_EN
    ,
    .squelch_thr  (squelch_thr),
    .low_conf_cnt (low_conf_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive one sample after the falling edge; in_ready is sampled before the rising edge
  task automatic send_sample(input int v, output logic rdy);
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    in_data  = v[DATA_W-1:0];
    #1 rdy = in_ready;
  endtask

  // bit 1: +amp for the first half of the symbol, -amp for the second half
  task automatic send_word(input logic [23:0] w, input int amp,
                           output logic rdy_last, output logic ov_before_last);
    logic rdy;
    int   v;
    for (int b = 23; b >= 0; b--) begin
      for (int s = 0; s < 8; s++) begin
        v = (w[b] ? amp : -amp) * ((s < 4) ? 1 : -1);
        if (b == 0 && s == 7) ov_before_last = out_valid;
        send_sample(v, rdy);
      end
    end
    rdy_last = rdy;
  endtask

  task automatic idle();
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    in_data  = '0;
    align    = 1'b0;
  endtask

  logic rl, ovb, rdy;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; align = 1'b0; out_ready = 1'b1;
`ifdef BPSK_DEMOD_SQUELCH_EN
    squelch_thr = ACC_W'(5000);
`endif
    #5;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;

    // clean word, latency of one cycle
    send_word(24'hA5C3F0, 1000, rl, ovb);
    check("w1_valid_before_last", 32'(ovb), 32'd0);
    idle();
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_data", 32'(out_data), 32'h00A5C3F0);
    idle();
    check("w1_handshake_clear", 32'(out_valid), 32'd0);

    // all-zero samples tie to 1
    for (int i = 0; i < 192; i++) send_sample(0, rdy);
    idle();
    check("zero_valid", 32'(out_valid), 32'd1);
    check("zero_data", 32'(out_data), 32'h00FFFFFF);
    idle();

    // back-to-back with no consumer: last sample of word 2 stalled and dropped
    out_ready = 1'b0;
    send_word(24'h5A0F3C, 1000, rl, ovb);
    send_word(24'h123ABC, 1000, rl, ovb);
    check("bb_in_ready_last", 32'(rl), 32'd0);
    idle();
    check("bb_overrun", 32'(overrun), 32'd1);
    check("bb_valid", 32'(out_valid), 32'd1);
    check("bb_data_held", 32'(out_data), 32'h005A0F3C);
    check("bb_in_ready_hold", 32'(in_ready), 32'd0);

    // reset mid-operation clears immediately
    @(negedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // pending word, garbage, align; the pending word must survive align
    out_ready = 1'b0;
    send_word(24'hC0FFEE, 1000, rl, ovb);
    for (int i = 0; i < 50; i++) send_sample((i % 3 == 0) ? 777 : -1234 + i, rdy);
    @(negedge CLOCK_50);
    align    = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'sd4321;
    idle();
    check("al_overrun", 32'(overrun), 32'd0);
    check("al_valid_kept", 32'(out_valid), 32'd1);
    check("al_data_kept", 32'(out_data), 32'h00C0FFEE);
    out_ready = 1'b1;
    idle();
    check("al_consumed", 32'(out_valid), 32'd0);
    send_word(24'h123456, 1000, rl, ovb);
    idle();
    check("al_word_valid", 32'(out_valid), 32'd1);
    check("al_word_data", 32'(out_data), 32'h00123456);
    check("al_word_overrun", 32'(overrun), 32'd0);
    idle();

`ifdef BPSK_DEMOD_SQUELCH_EN
    @(negedge CLOCK_50);
    align = 1'b1;
    idle();
    check("sq_cleared", 32'(low_conf_cnt), 32'd0);
    send_word(24'h9E3779, 100, rl, ovb);
    idle();
    check("sq_data", 32'(out_data), 32'h009E3779);
    check("sq_low_conf", 32'(low_conf_cnt), 32'd24);
    send_word(24'h000001, 1000, rl, ovb);
    idle();
    check("sq_strong_no_inc", 32'(low_conf_cnt), 32'd24);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
